// File: rtl/planificador_tx_p2s_if.sv
// Byte-request and serializer-feed bundle of the transmit scheduler.
// master: requester/consumer side; slave: the scheduler itself.
interface planificador_tx_p2s_if;
    logic [7:0] data_in0;
    logic       valid_in0;
    logic       ready0;
    logic [7:0] data_in1;
    logic       valid_in1;
    logic       ready1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       lane_out;
    logic       sync_done;

    modport master (
        output data_in0, valid_in0, data_in1, valid_in1,
        input  ready0, ready1, data_out, valid_out, lane_out, sync_done
    );

    modport slave (
        input  data_in0, valid_in0, data_in1, valid_in1,
        output ready0, ready1, data_out, valid_out, lane_out, sync_done
    );
endinterface

// File: rtl/planificador_tx_p2s.sv
// Transmit scheduler for the paralelo_serial lane: sends a comma training
// burst after reset, then shares the byte slot between two requesters with
// round-robin arbitration, inserting a comma every SYNC_INTERVAL slots.
module planificador_tx_p2s #(
    parameter logic [7:0] COMMA         = 8'hBC,
    parameter logic [7:0] IDLE          = 8'h7C,
    parameter int         N_SYNC        = 4,
    parameter int         SYNC_INTERVAL = 64
) (
    input  logic                 clk_4f,
    input  logic                 reset,
    planificador_tx_p2s_if.slave bus
);
    localparam int SYNC_W = ($clog2(N_SYNC + 1) > 3) ? $clog2(N_SYNC + 1) : 3;
    localparam int INT_W  = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(N_SYNC - 1);
    localparam logic [INT_W-1:0]  INT_LAST  =
        (SYNC_INTERVAL > 0) ? INT_W'(SYNC_INTERVAL - 1) : '0;
    localparam bit INT_EN = (SYNC_INTERVAL != 0);

    typedef enum logic [1:0] {ST_RST, ST_SYNC, ST_ACTIVE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              lane_q, lane_d;
    logic              sync_done_q, sync_done_d;
    logic              rr_q, rr_d;          // 0: lane 0 wins a tie, 1: lane 1
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [INT_W-1:0]  int_cnt_q, int_cnt_d;
    logic              comma_slot;
    logic              gnt0, gnt1;

    // Slot classification, grant decision and next-state/output computation
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        lane_d      = lane_q;
        sync_done_d = sync_done_q;
        rr_d        = rr_q;
        sync_cnt_d  = sync_cnt_q;
        int_cnt_d   = int_cnt_q;
        comma_slot  = INT_EN && (int_cnt_q == INT_LAST);
        gnt0        = 1'b0;
        gnt1        = 1'b0;

        // Ready is suppressed while reset is asserted so no requester sees
        // an acceptance for a byte that reset is about to discard.
        if (state_q == ST_ACTIVE && !comma_slot && !reset) begin
            gnt0 = bus.valid_in0 && (!bus.valid_in1 || !rr_q);
            gnt1 = bus.valid_in1 && (!bus.valid_in0 ||  rr_q);
        end

        case (state_q)
            ST_RST: begin
                state_d     = ST_SYNC;
                data_d      = IDLE;
                sync_done_d = 1'b0;
                rr_d        = 1'b0;
                sync_cnt_d  = '0;
                int_cnt_d   = '0;
            end
            ST_SYNC: begin
                data_d      = COMMA;
                sync_done_d = 1'b0;
                sync_cnt_d  = sync_cnt_q + 1'b1;
                if (sync_cnt_q == SYNC_LAST) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                sync_done_d = 1'b1;
                if (comma_slot) begin
                    data_d    = COMMA;
                    int_cnt_d = '0;
                end else begin
                    int_cnt_d = INT_EN ? (int_cnt_q + 1'b1) : '0;
                    if (gnt0) begin
                        data_d  = bus.data_in0;
                        valid_d = 1'b1;
                        lane_d  = 1'b0;
                        rr_d    = 1'b1;
                    end else if (gnt1) begin
                        data_d  = bus.data_in1;
                        valid_d = 1'b1;
                        lane_d  = 1'b1;
                        rr_d    = 1'b0;
                    end else begin
                        data_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // State and registered outputs; reset overrides any in-flight byte
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q     <= ST_RST;
            data_q      <= IDLE;
            valid_q     <= 1'b0;
            lane_q      <= 1'b0;
            sync_done_q <= 1'b0;
            rr_q        <= 1'b0;
            sync_cnt_q  <= '0;
            int_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            lane_q      <= lane_d;
            sync_done_q <= sync_done_d;
            rr_q        <= rr_d;
            sync_cnt_q  <= sync_cnt_d;
            int_cnt_q   <= int_cnt_d;
        end
    end

    assign bus.ready0    = gnt0;
    assign bus.ready1    = gnt1;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.lane_out  = lane_q;
    assign bus.sync_done = sync_done_q;
endmodule

// File: tb/tb_planificador_tx_p2s.sv
// Directed bench for planificador_tx_p2s (N_SYNC=4, SYNC_INTERVAL=8).
module tb_planificador_tx_p2s;
    logic clk_4f = 1'b0;
    logic reset  = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    planificador_tx_p2s_if bus ();

    planificador_tx_p2s #(
        .COMMA(8'hBC), .IDLE(8'h7C), .N_SYNC(4), .SYNC_INTERVAL(8)
    ) dut (
        .clk_4f(clk_4f),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One ACTIVE slot: drive, check ready mid-cycle, check registered output.
    task automatic slot(input string tag,
                        input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1,
                        input logic er0, input logic er1,
                        input logic [7:0] ed, input logic ev, input logic el);
        bus.valid_in0 = v0;
        bus.data_in0  = d0;
        bus.valid_in1 = v1;
        bus.data_in1  = d1;
        @(negedge clk_4f);
        chk({tag, ".ready0"}, 8'(bus.ready0), 8'(er0));
        chk({tag, ".ready1"}, 8'(bus.ready1), 8'(er1));
        chk({tag, ".both_ready"}, 8'(bus.ready0 & bus.ready1), 8'h00);
        @(posedge clk_4f);
        #1;
        chk({tag, ".data_out"}, bus.data_out, ed);
        chk({tag, ".valid_out"}, 8'(bus.valid_out), 8'(ev));
        chk({tag, ".lane_out"}, 8'(bus.lane_out), 8'(el));
        chk({tag, ".sync_done"}, 8'(bus.sync_done), 8'h01);
    endtask

    // Two reset cycles, the RST cycle, then the four-comma training burst.
    task automatic do_reset(input string tag, input bit drop_valid);
        if (drop_valid) begin
            bus.valid_in0 = 1'b0;
            bus.valid_in1 = 1'b0;
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk_4f);
            chk({tag, ".rst_ready0"}, 8'(bus.ready0), 8'h00);
            chk({tag, ".rst_ready1"}, 8'(bus.ready1), 8'h00);
            @(posedge clk_4f);
            #1;
            chk({tag, ".rst_data"}, bus.data_out, 8'h7C);
            chk({tag, ".rst_valid"}, 8'(bus.valid_out), 8'h00);
            chk({tag, ".rst_lane"}, 8'(bus.lane_out), 8'h00);
            chk({tag, ".rst_sync_done"}, 8'(bus.sync_done), 8'h00);
        end
        reset = 1'b0;
        @(negedge clk_4f);
        chk({tag, ".rstst_ready"}, 8'({bus.ready1, bus.ready0}), 8'h00);
        @(posedge clk_4f);
        #1;
        chk({tag, ".rstst_data"}, bus.data_out, 8'h7C);
        chk({tag, ".rstst_sync_done"}, 8'(bus.sync_done), 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_4f);
            chk($sformatf("%s.sync%0d_ready", tag, i), 8'({bus.ready1, bus.ready0}), 8'h00);
            @(posedge clk_4f);
            #1;
            chk($sformatf("%s.sync%0d_data", tag, i), bus.data_out, 8'hBC);
            chk($sformatf("%s.sync%0d_valid", tag, i), 8'(bus.valid_out), 8'h00);
            chk($sformatf("%s.sync%0d_done", tag, i), 8'(bus.sync_done), 8'h00);
        end
    endtask

    initial begin
        int k;
        bus.data_in0  = 8'h00;
        bus.valid_in0 = 1'b0;
        bus.data_in1  = 8'h00;
        bus.valid_in1 = 1'b0;

        // Reset then idle: sync_done rises with the first IDLE byte
        do_reset("idle", 1'b1);
        slot("idle.s0", 0, 8'h00, 0, 8'h00, 0, 0, 8'h7C, 0, 0);
        slot("idle.s1", 0, 8'h00, 0, 8'h00, 0, 0, 8'h7C, 0, 0);

        // Single lane stream
        do_reset("single", 1'b1);
        slot("single.s0", 1, 8'h11, 0, 8'h00, 1, 0, 8'h11, 1, 0);
        slot("single.s1", 1, 8'h22, 0, 8'h00, 1, 0, 8'h22, 1, 0);
        slot("single.s2", 1, 8'h33, 0, 8'h00, 1, 0, 8'h33, 1, 0);
        slot("single.s3", 0, 8'h00, 0, 8'h00, 0, 0, 8'h7C, 0, 0);

        // Contention: alternation starting at lane 0; lane_out holds on idle
        do_reset("cont", 1'b1);
        slot("cont.s0", 1, 8'hA0, 1, 8'hB0, 1, 0, 8'hA0, 1, 0);
        slot("cont.s1", 1, 8'hA1, 1, 8'hB0, 0, 1, 8'hB0, 1, 1);
        slot("cont.s2", 1, 8'hA1, 1, 8'hB1, 1, 0, 8'hA1, 1, 0);
        slot("cont.s3", 1, 8'hA2, 1, 8'hB1, 0, 1, 8'hB1, 1, 1);
        slot("cont.s4", 0, 8'h00, 0, 8'h00, 0, 0, 8'h7C, 0, 1);

        // Periodic comma: slots 7 and 15 are commas, lane 1 bytes continuous
        do_reset("comma", 1'b1);
        k = 0;
        for (int s = 0; s < 17; s++) begin
            if (s % 8 == 7) begin
                slot($sformatf("comma.s%0d", s), 0, 8'h00, 1, 8'(8'hC0 + k),
                     0, 0, 8'hBC, 0, 1);
            end else begin
                slot($sformatf("comma.s%0d", s), 0, 8'h00, 1, 8'(8'hC0 + k),
                     0, 1, 8'(8'hC0 + k), 1, 1);
                k++;
            end
        end

        // Withdrawn request: lane 1 drops valid before ever being granted
        do_reset("wdraw", 1'b1);
        slot("wdraw.s0", 1, 8'hD0, 1, 8'hE0, 1, 0, 8'hD0, 1, 0);
        slot("wdraw.s1", 1, 8'hD1, 0, 8'hE0, 1, 0, 8'hD1, 1, 0);
        slot("wdraw.s2", 1, 8'hD2, 0, 8'hE0, 1, 0, 8'hD2, 1, 0);
        slot("wdraw.s3", 0, 8'h00, 0, 8'h00, 0, 0, 8'h7C, 0, 0);

        // Reset mid-stream: pointer left at lane 1, restart must favour lane 0
        do_reset("mid", 1'b1);
        slot("mid.s0", 1, 8'hA0, 1, 8'hB0, 1, 0, 8'hA0, 1, 0);
        slot("mid.s1", 1, 8'hA1, 1, 8'hB0, 0, 1, 8'hB0, 1, 1);
        slot("mid.s2", 1, 8'hA1, 1, 8'hB1, 1, 0, 8'hA1, 1, 0);
        bus.data_in0 = 8'hA2;
        do_reset("mid.rst", 1'b0);
        slot("mid.r0", 1, 8'hA2, 1, 8'hB1, 1, 0, 8'hA2, 1, 0);
        slot("mid.r1", 1, 8'hA3, 1, 8'hB1, 0, 1, 8'hB1, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/planificador_tx_p2s.md
Name: planificador_tx_p2s

Overview:
- Transmit-side scheduler in front of the paralelo_serial transmitter, in the clk_4f byte domain.
- Shares one serial lane between two 8-bit byte requesters (lane 0, lane 1) using round-robin arbitration.
- Sends the initial comma (0xBC) training burst so serial_paralelo can lock, and re-inserts commas periodically.
- Drives the byte/valid pair that paralelo_serial consumes.

Parameters:
- COMMA, 8'hBC, sync/training byte.
- IDLE, 8'h7C, filler byte sent when no requester has data.
- N_SYNC, 4, number of consecutive COMMA bytes sent after reset (must be ≥1).
- SYNC_INTERVAL, 64, ACTIVE-state byte slots between inserted commas; 0 disables periodic insertion.

Ports:
- clk_4f  input  1  byte clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- data_in0  input  8  lane 0 byte
- valid_in0  input  1  lane 0 has a byte
- ready0  output  1  lane 0 byte accepted this cycle
- data_in1  input  8  lane 1 byte
- valid_in1  input  1  lane 1 has a byte
- ready1  output  1  lane 1 byte accepted this cycle
- data_out  output  8  byte to paralelo_serial
- valid_out  output  1  data_out carries requester data
- lane_out  output  1  source lane of the current data_out (valid only when valid_out=1)
- sync_done  output  1  training burst complete; ACTIVE state

Behaviour:
- One clock (clk_4f); reset is synchronous and active-high, sampled on the rising edge. Reset has priority over everything, including mid-burst and mid-byte.
- Reset values:
  - data_out=IDLE, valid_out=0, lane_out=0, sync_done=0, ready0=ready1=0.
  - rr pointer=0 (lane 0 has priority first); sync counter=0; interval counter=0.
- State machine:
  - RST: entered on reset. The first cycle after reset deasserts goes to SYNC.
  - SYNC: each cycle registers data_out=COMMA, valid_out=0, and increments the sync counter. After N_SYNC commas have been registered, go to ACTIVE. Ready outputs are held at 0.
  - ACTIVE: sync_done=1. Each cycle is one slot, used as follows:
    - Comma slot: if SYNC_INTERVAL≠0 and the interval counter = SYNC_INTERVAL−1, the slot is a comma slot: data_out=COMMA, valid_out=0, both ready=0, interval counter←0.
    - Otherwise, grant per the rules below, and the interval counter increments.
- Handshake/grant (combinational ready; registered data):
  - readyX=1 only in ACTIVE, in a non-comma slot, with valid_inX=1 and lane X granted.
  - Only one requester valid: grant it.
  - Both valid: grant the lane indicated by the rr pointer, then the pointer flips to the other lane.
  - Single grant: the pointer is set to the non-granted lane.
  - No grant: the pointer is unchanged.
  - A transfer occurs when valid_inX & readyX. On the next edge: data_out=data_inX, valid_out=1, lane_out=X. Latency is exactly 1 clk_4f.
  - No valid requester: data_out=IDLE, valid_out=0, lane_out holds its previous value.
  - Requesters must hold data_inX/valid_inX stable until readyX is sampled high. Deasserting valid without a transfer is legal; no byte is lost or duplicated.
  - At most one ready is high per cycle; ready0&ready1 never occurs.
- Counters:
  - Sync counter is 3 bits min, sized for N_SYNC, with no wrap.
  - Interval counter is sized for SYNC_INTERVAL and wraps only through a comma slot.
- Reset mid-operation: any in-flight byte is discarded; the next non-reset cycle restarts SYNC.

Test Plan:
- Reset then idle:
  - Stimulus: reset high 2 cycles, then valid_in0=valid_in1=0.
  - Required response: data_out=0xBC for exactly 4 cycles with valid_out=0; sync_done rises on cycle 5; then data_out=0x7C, valid_out=0.
- Single lane stream:
  - Stimulus: after sync, lane 0 presents 0x11,0x22,0x33 back-to-back.
  - Required response: ready0=1 each cycle; data_out=0x11,0x22,0x33 one cycle later with valid_out=1, lane_out=0.
- Contention:
  - Stimulus: both lanes valid continuously (lane 0 0xA0.., lane 1 0xB0..).
  - Required response: grants alternate 0,1,0,1 starting at lane 0; data_out alternates 0xA0,0xB0,0xA1,0xB1; never both ready.
- Periodic comma:
  - Stimulus: SYNC_INTERVAL=8, lane 1 always valid.
  - Required response: every 8th ACTIVE slot data_out=0xBC, valid_out=0, ready1=0; no lane 1 byte is skipped or repeated.
- Withdrawn request:
  - Stimulus: lane 1 asserts valid while lane 0 is granted, then drops it before being granted.
  - Required response: no lane 1 byte appears on data_out.
- Reset mid-stream:
  - Stimulus: assert reset during contention.
  - Required response: outputs return to reset values next edge; 4 commas are re-sent; arbitration restarts with lane 0.
